// File: rtl/mopshub_scan_pkg.sv
// Purpose: shared types and constants for the MOPS-Hub bus scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mopshub_scan_pkg;

    localparam int N_CH  = 16;
    localparam int SEL_W = 5;

    // Select code that makes mux16_1_1bit drive its default value.
    localparam logic [SEL_W-1:0] SEL_IDLE = 5'h1F;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } scan_state_t;

endpackage

// File: rtl/mopshub_bus_scanner_rr_enc.sv
// Purpose: round-robin priority encoder, first set bit at or after start_idx with wrap.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   elig      in  16  eligible channel vector
//   start_idx in  4   channel where the search begins
//   winner    out 4   first eligible channel found (0 when none)
//   found     out 1   at least one channel is eligible
module rr_priority_encoder16
    import mopshub_scan_pkg::*;
(
    input  logic [N_CH-1:0] elig,
    input  logic [3:0]      start_idx,
    output logic [3:0]      winner,
    output logic            found
);

    logic [3:0] idx;

    // Walk offsets from the farthest to the nearest so the nearest eligible
    // channel is the last assignment and therefore wins.
    always_comb begin
        winner = 4'd0;
        found  = 1'b0;
        idx    = 4'd0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = start_idx + 4'(i);
            if (elig[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mopshub_bus_scanner.sv
// Purpose: round-robin scanner driving the 5-bit sel of mux16_1_1bit, one grant at a time.
// Latency: sel 1 cycle after an eligible request is seen in IDLE, grant_valid 1 cycle later.
// Backpressure: holds sel until done (or watchdog expiry); en only gates new grants.
//
// Optional feature: define MOPSHUB_SCAN_TIMEOUT_EN to build the HOLD watchdog and
// the timeout pulse; without it HOLD exits only on done or rst and timeout is 0.
//
// Ports:
//   clk         in  1   clock, rising edge
//   rst         in  1   synchronous active-high reset
//   en          in  1   permits new grants
//   ch_mask     in  16  per-channel enable
//   req         in  16  per-channel level request
//   done        in  1   downstream transaction complete (sampled in HOLD only)
//   sel         out 5   mux channel select, SEL_IDLE when nothing is selected
//   grant_valid out 1   mux output carries the selected channel's data
//   busy        out 1   scanner is not in IDLE
//   timeout     out 1   one-cycle pulse when the watchdog ended HOLD
module mopshub_bus_scanner
    import mopshub_scan_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TMR_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_CH-1:0]  ch_mask,
    input  logic [N_CH-1:0]  req,
    input  logic             done,
    output logic [SEL_W-1:0] sel,
    output logic             grant_valid,
    output logic             busy,
    output logic             timeout
);

    scan_state_t      state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             grant_valid_q, grant_valid_d;
    logic             busy_q, busy_d;
    logic [3:0]       last_ch_q, last_ch_d;
    logic [3:0]       winner;
    logic             found;

    rr_priority_encoder16 u_rr_enc (
        .elig      (req & ch_mask),
        .start_idx (last_ch_q + 4'd1),
        .winner    (winner),
        .found     (found)
    );

`ifdef MOPSHUB_SCAN_TIMEOUT_EN
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             timeout_q, timeout_d;
`else
    wire unused_tmr_cfg = ^{TMR_W'(TIMEOUT_CYCLES)};
`endif

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        grant_valid_d = grant_valid_q;
        last_ch_d     = last_ch_q;
`ifdef MOPSHUB_SCAN_TIMEOUT_EN
        tmr_d         = tmr_q;
        timeout_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (en && found) begin
                    sel_d   = {1'b0, winner};
                    state_d = ST_SETTLE;
                end
            end
            // One dead cycle while the mux output register catches up with sel.
            ST_SETTLE: begin
                state_d       = ST_HOLD;
                grant_valid_d = 1'b1;
`ifdef MOPSHUB_SCAN_TIMEOUT_EN
                tmr_d         = '0;
`endif
            end
            ST_HOLD: begin
                // done has priority over a simultaneous watchdog expiry.
                if (done) begin
                    grant_valid_d = 1'b0;
                    last_ch_d     = sel_q[3:0];
                    state_d       = ST_RELEASE;
                end
`ifdef MOPSHUB_SCAN_TIMEOUT_EN
                else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    grant_valid_d = 1'b0;
                    last_ch_d     = sel_q[3:0];
                    state_d       = ST_RELEASE;
                    timeout_d     = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
`endif
            end
            ST_RELEASE: begin
                sel_d   = SEL_IDLE;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = SEL_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            sel_q         <= SEL_IDLE;
            grant_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            last_ch_q     <= 4'hF;
`ifdef MOPSHUB_SCAN_TIMEOUT_EN
            tmr_q         <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            grant_valid_q <= grant_valid_d;
            busy_q        <= busy_d;
            last_ch_q     <= last_ch_d;
`ifdef MOPSHUB_SCAN_TIMEOUT_EN
            tmr_q         <= tmr_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

    assign sel         = sel_q;
    assign grant_valid = grant_valid_q;
    assign busy        = busy_q;
`ifdef MOPSHUB_SCAN_TIMEOUT_EN
    assign timeout     = timeout_q;
`else
    assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_mopshub_bus_scanner.sv
// Purpose: directed self-checking bench for mopshub_bus_scanner.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled there too.
// Backpressure: done pulses are driven by the bench as the downstream side.
module tb_mopshub_bus_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] ch_mask;
    logic [15:0] req;
    logic        done;
    logic [4:0]  sel;
    logic        grant_valid;
    logic        busy;
    logic        timeout;

    int n_checks = 0;
    int n_errors = 0;

    logic mask_phase = 1'b0;
    logic saw_sel0   = 1'b0;

    always #5 clk = ~clk;

    mopshub_bus_scanner #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ch_mask     (ch_mask),
        .req         (req),
        .done        (done),
        .sel         (sel),
        .grant_valid (grant_valid),
        .busy        (busy),
        .timeout     (timeout)
    );

    always @(negedge clk) begin
        if (mask_phase && sel == 5'd0) saw_sel0 <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b1; req = 16'h0; ch_mask = 16'hFFFF; done = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Waits (bounded) for grant_valid, checks the granted channel, then
    // answers with done two cycles later and checks the release sequence.
    task automatic grant_cycle(input string tag, input logic [4:0] exp_ch);
        int n = 0;
        while (grant_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_gv"}, {31'd0, grant_valid}, 32'd1);
        chk({tag, "_sel"}, {27'd0, sel}, {27'd0, exp_ch});
        step();
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        chk({tag, "_gv_fall"}, {31'd0, grant_valid}, 32'd0);
        step();
        chk({tag, "_sel_park"}, {27'd0, sel}, 32'h1F);
    endtask

    initial begin
        do_reset();
        chk("rst_sel", {27'd0, sel}, 32'h1F);
        chk("rst_gv", {31'd0, grant_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);

        // Basic grant timing.
        req = 16'h0001;
        step();
        chk("basic_sel1", {27'd0, sel}, 32'd0);
        chk("basic_gv1", {31'd0, grant_valid}, 32'd0);
        chk("basic_busy1", {31'd0, busy}, 32'd1);
        step();
        chk("basic_gv2", {31'd0, grant_valid}, 32'd1);
        step();
        step();
        done = 1'b1;
        req  = 16'h0;
        step();
        done = 1'b0;
        chk("basic_gv5", {31'd0, grant_valid}, 32'd0);
        chk("basic_sel5", {27'd0, sel}, 32'd0);
        step();
        chk("basic_sel6", {27'd0, sel}, 32'h1F);
        chk("basic_busy6", {31'd0, busy}, 32'd0);

        // Round robin from reset: 0, 2, 15, 0.
        do_reset();
        req = 16'h8005;
        grant_cycle("rr0", 5'd0);
        grant_cycle("rr1", 5'd2);
        grant_cycle("rr2", 5'd15);
        grant_cycle("rr3", 5'd0);
        req = 16'h0;
        repeat (6) step();

        // Masked channel 0 is never granted.
        do_reset();
        req        = 16'h0003;
        ch_mask    = 16'hFFFE;
        mask_phase = 1'b1;
        grant_cycle("mask0", 5'd1);
        grant_cycle("mask1", 5'd1);
        grant_cycle("mask2", 5'd1);
        mask_phase = 1'b0;
        chk("mask_never0", {31'd0, saw_sel0}, 32'd0);

        // done during IDLE/SETTLE is ignored, taken on first HOLD cycle.
        do_reset();
        req  = 16'h0020;
        done = 1'b1;
        step();
        step();
        chk("early_done_gv", {31'd0, grant_valid}, 32'd1);
        chk("early_done_sel", {27'd0, sel}, 32'd5);
        req = 16'h0;
        step();
        done = 1'b0;
        chk("early_done_fall", {31'd0, grant_valid}, 32'd0);
        step();
        chk("early_done_park", {27'd0, sel}, 32'h1F);

        // en and req dropped mid-grant: grant completes, no new grant.
        do_reset();
        req = 16'h0004;
        step();
        step();
        en  = 1'b0;
        req = 16'h0;
        repeat (5) step();
        chk("en_mid_gv", {31'd0, grant_valid}, 32'd1);
        chk("en_mid_sel", {27'd0, sel}, 32'd2);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("en_mid_fall", {31'd0, grant_valid}, 32'd0);
        req = 16'h0004;
        repeat (10) step();
        chk("en_off_busy", {31'd0, busy}, 32'd0);
        chk("en_off_sel", {27'd0, sel}, 32'h1F);
        // Single eligible channel is re-granted once en returns.
        en = 1'b1;
        grant_cycle("regrant", 5'd2);

        // Reset during HOLD.
        step();
        step();
        chk("rst_hold_gv_pre", {31'd0, grant_valid}, 32'd1);
        rst  = 1'b1;
        done = 1'b1;
        step();
        chk("rst_hold_sel", {27'd0, sel}, 32'h1F);
        chk("rst_hold_gv", {31'd0, grant_valid}, 32'd0);
        chk("rst_hold_busy", {31'd0, busy}, 32'd0);
        rst  = 1'b0;
        done = 1'b0;
        req  = 16'h0;
        step();

`ifdef MOPSHUB_SCAN_TIMEOUT_EN
        begin
            int n;
            int hi;
            logic early_to;
            do_reset();
            req = 16'h0010;
            n = 0;
            while (grant_valid !== 1'b1 && n < 40) begin
                step();
                n++;
            end
            hi = 0;
            early_to = 1'b0;
            while (grant_valid === 1'b1 && hi < 40) begin
                if (timeout !== 1'b0) early_to = 1'b1;
                step();
                hi++;
            end
            chk("to_gv_cycles", hi, 32'd8);
            chk("to_no_early", {31'd0, early_to}, 32'd0);
            chk("to_pulse", {31'd0, timeout}, 32'd1);
            chk("to_sel_hold", {27'd0, sel}, 32'd4);
            step();
            chk("to_pulse_end", {31'd0, timeout}, 32'd0);
            // Second grant: done on the expiry cycle suppresses the pulse.
            n = 0;
            while (grant_valid !== 1'b1 && n < 40) begin
                step();
                n++;
            end
            chk("to2_gv", {31'd0, grant_valid}, 32'd1);
            repeat (7) step();
            chk("to2_gv_pre", {31'd0, grant_valid}, 32'd1);
            done = 1'b1;
            req  = 16'h0;
            step();
            done = 1'b0;
            chk("to2_gv_fall", {31'd0, grant_valid}, 32'd0);
            chk("to2_no_pulse", {31'd0, timeout}, 32'd0);
            step();
            chk("to2_no_pulse_late", {31'd0, timeout}, 32'd0);
        end
`else
        begin
            logic gv_drop;
            logic to_seen;
            do_reset();
            req = 16'h0010;
            step();
            step();
            gv_drop = 1'b0;
            to_seen = 1'b0;
            for (int i = 0; i < 5000; i++) begin
                if (grant_valid !== 1'b1) gv_drop = 1'b1;
                if (timeout !== 1'b0) to_seen = 1'b1;
                step();
            end
            chk("nowd_gv_held", {31'd0, gv_drop}, 32'd0);
            chk("nowd_no_timeout", {31'd0, to_seen}, 32'd0);
            chk("nowd_sel", {27'd0, sel}, 32'd4);
            done = 1'b1;
            req  = 16'h0;
            step();
            done = 1'b0;
            chk("nowd_fall", {31'd0, grant_valid}, 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
